// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Two-of-three vote used to reject single-sample line noise.
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver boundary bundle: serial line and frame options in, byte and status pulses out.
// Handshake: there is no ready. data_valid, par_err and stop_err are single-cycle
// strobes; the consumer must take P_DATA in the cycle data_valid is high (P_DATA
// then holds until the next good frame). Option inputs are sampled at frame start.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  par_en;
    logic                  par_typ;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stop_err;

    modport master (
        output RX_IN, par_en, par_typ,
        input  P_DATA, data_valid, par_err, stop_err
    );

    modport slave (
        input  RX_IN, par_en, par_typ,
        output P_DATA, data_valid, par_err, stop_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit timing for the receiver: per-bit edge counter, three mid-bit samples and a vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic active,      // FSM is inside a frame
    input  logic rx_s,        // synchronised serial line
    output logic bit_tick,    // last cycle of the current bit
    output logic sample_rdy,  // voted bit is valid this cycle
    output logic voted
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] S0   = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] S1   = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] S2   = CW'(PRESCALE / 2 + 1);
    localparam logic [CW-1:0] RDY  = CW'(PRESCALE / 2 + 2);

    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]    samp_q, samp_d;

    // Count within the bit while a frame is active; capture the three centre samples.
    always_comb begin
        edge_cnt_d = '0;
        samp_d     = samp_q;
        if (active) begin
            edge_cnt_d = (edge_cnt_q == LAST) ? '0 : edge_cnt_q + 1'b1;
            if (edge_cnt_q == S0) samp_d[0] = rx_s;
            if (edge_cnt_q == S1) samp_d[1] = rx_s;
            if (edge_cnt_q == S2) samp_d[2] = rx_s;
        end
    end

    // Counter and sample registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            edge_cnt_q <= '0;
            samp_q     <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            samp_q     <= samp_d;
        end
    end

    assign bit_tick   = active && (edge_cnt_q == LAST);
    assign sample_rdy = active && (edge_cnt_q == RDY);
    assign voted      = majority3(samp_q);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with registered result pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic      clk,
    input  logic      rstn,
    uart_rx_if.slave  bus,
    output rx_state_t dbg_state
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_t             state_q, state_d;
    logic                  rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  par_mis_q, par_mis_d, stop_bit_q, stop_bit_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d, stop_err_q, stop_err_d;
    logic                  active, bit_tick, sample_rdy, voted;

    assign active = (state_q != IDLE);

    uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
        .clk        (clk),
        .rstn       (rstn),
        .active     (active),
        .rx_s       (rx_s_q),
        .bit_tick   (bit_tick),
        .sample_rdy (sample_rdy),
        .voted      (voted)
    );

    // Frame FSM, shift register, parity/stop evaluation and result pulses.
    always_comb begin
        rx_meta_d    = bus.RX_IN;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_mis_d    = par_mis_q;
        stop_bit_d   = stop_bit_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stop_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    par_en_d  = bus.par_en;
                    par_typ_d = bus.par_typ;
                    par_mis_d = 1'b0;
                end
            end
            START: begin
                // A start bit that votes high was a glitch; drop it silently.
                if (sample_rdy && voted) begin
                    state_d = IDLE;
                end else if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_rdy) shift_d = {voted, shift_q[DATA_WIDTH-1:1]};
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample_rdy) par_mis_d = (voted != ((^shift_q) ^ (par_typ_q == PAR_ODD)));
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                if (sample_rdy) stop_bit_d = voted;
                if (bit_tick) begin
                    if (!stop_bit_q) begin
                        stop_err_d = 1'b1;
                        par_err_d  = par_mis_q;
                    end else if (par_mis_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    // A low line here is already the next start bit.
                    if (!rx_s_q) begin
                        state_d   = START;
                        par_en_d  = bus.par_en;
                        par_typ_d = bus.par_typ;
                        par_mis_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; synchroniser flops reset to the idle line level.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_mis_q    <= 1'b0;
            stop_bit_q   <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_mis_q    <= par_mis_d;
            stop_bit_q   <= stop_bit_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stop_err   = stop_err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at PRESCALE=8, one at PRESCALE=16.
module tb_uart_rx;
    import uart_pkg::*;

    logic      clk = 1'b0;
    logic      rstn;
    rx_state_t st8, st16;

    uart_rx_if #(.DATA_WIDTH(8)) b8 ();
    uart_rx_if #(.DATA_WIDTH(8)) b16 ();

    uart_rx #(.PRESCALE(8), .DATA_WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .bus(b8), .dbg_state(st8)
    );
    uart_rx #(.PRESCALE(16), .DATA_WIDTH(8)) dut16 (
        .clk(clk), .rstn(rstn), .bus(b16), .dbg_state(st16)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp8_q[$];
    logic [7:0] exp16_q[$];
    int dv8 = 0, pe8 = 0, se8 = 0, dv16 = 0;
    int dv16_cyc[$];
    logic [2:0] prev8 = '0;

    always @(negedge clk) begin
        if (b8.data_valid || b8.par_err || b8.stop_err) begin
            check("excl8", {31'd0, b8.data_valid & (b8.par_err | b8.stop_err)}, 32'd0);
            check("width8", {29'd0, prev8 & {b8.data_valid, b8.par_err, b8.stop_err}}, 32'd0);
        end
        if (b8.data_valid) begin
            dv8++;
            if (exp8_q.size() == 0) check("dv8_unexpected", 32'd1, 32'd0);
            else check("p_data8", {24'd0, b8.P_DATA}, {24'd0, exp8_q.pop_front()});
        end
        if (b8.par_err)  pe8++;
        if (b8.stop_err) se8++;
        prev8 = {b8.data_valid, b8.par_err, b8.stop_err};
    end

    always @(negedge clk) begin
        if (b16.par_err || b16.stop_err) check("err16", 32'd1, 32'd0);
        if (b16.data_valid) begin
            dv16++;
            dv16_cyc.push_back(cyc);
            if (exp16_q.size() == 0) check("dv16_unexpected", 32'd1, 32'd0);
            else check("p_data16", {24'd0, b16.P_DATA}, {24'd0, exp16_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    int base_dv, base_pe, base_se;

    task automatic mark();
        base_dv = dv8;
        base_pe = pe8;
        base_se = se8;
    endtask

    task automatic expect8(input string tag, input int edv, input int epe, input int ese);
        check({tag, "_dv"}, dv8 - base_dv, edv);
        check({tag, "_pe"}, pe8 - base_pe, epe);
        check({tag, "_se"}, se8 - base_se, ese);
    endtask

    task automatic send_bit(input int sel, input logic v);
        if (sel == 8) b8.RX_IN = v;
        else b16.RX_IN = v;
        repeat (sel) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic pbit, input logic stopb);
        if (sel == 8) begin
            b8.par_en = pen;  b8.par_typ = ptyp;
        end else begin
            b16.par_en = pen; b16.par_typ = ptyp;
        end
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (pen) send_bit(sel, pbit);
        send_bit(sel, stopb);
    endtask

    task automatic idle(input int sel, input int bits);
        for (int i = 0; i < bits; i++) send_bit(sel, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b0;
        b8.RX_IN  = 1'b1; b8.par_en  = 1'b0; b8.par_typ  = 1'b0;
        b16.RX_IN = 1'b1; b16.par_en = 1'b0; b16.par_typ = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_p_data", {24'd0, b8.P_DATA}, 32'd0);
        check("rst_pulses", {29'd0, b8.data_valid, b8.par_err, b8.stop_err}, 32'd0);
        check("rst_state", {29'd0, st8}, {29'd0, IDLE});
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // 0xA5 with even parity (four ones -> parity bit 0)
        mark();
        exp8_q.push_back(8'hA5);
        send_frame(8, 8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1);
        idle(8, 2);
        expect8("a5_even", 1, 0, 0);
        check("a5_even_pdata", {24'd0, b8.P_DATA}, 32'h0000_00A5);

        // 0xA5 with odd parity but parity bit 0 -> parity error only
        mark();
        send_frame(8, 8'hA5, 1'b1, PAR_ODD, 1'b0, 1'b1);
        idle(8, 2);
        expect8("a5_odd", 0, 1, 0);
        check("a5_odd_pdata", {24'd0, b8.P_DATA}, 32'h0000_00A5);

        // 0x3C without parity, stop bit 0 -> stop error only
        mark();
        send_frame(8, 8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        idle(8, 2);
        expect8("stop0", 0, 0, 1);
        check("stop0_pdata", {24'd0, b8.P_DATA}, 32'h0000_00A5);
        check("stop0_state", {29'd0, st8}, {29'd0, IDLE});

        // 3-cycle glitch is rejected, following 0x81 is received
        mark();
        b8.RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        b8.RX_IN = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch_state", {29'd0, st8}, {29'd0, IDLE});
        expect8("glitch", 0, 0, 0);
        mark();
        exp8_q.push_back(8'h81);
        send_frame(8, 8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        idle(8, 2);
        expect8("f81", 1, 0, 0);
        check("f81_pdata", {24'd0, b8.P_DATA}, 32'h0000_0081);

        // Break: line low past the stop bit, then released early in the restarted start bit
        mark();
        b8.RX_IN = 1'b0;
        repeat (10 * 8 + 2) @(negedge clk);
        b8.RX_IN = 1'b1;
        idle(8, 3);
        expect8("break", 0, 0, 1);
        check("break_state", {29'd0, st8}, {29'd0, IDLE});

        // Reset in the middle of 0xFF, then clean 0x5A
        mark();
        send_bit(8, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(8, 1'b1);
        rstn = 1'b0;
        b8.RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_pdata", {24'd0, b8.P_DATA}, 32'd0);
        check("midrst_state", {29'd0, st8}, {29'd0, IDLE});
        check("midrst_pulses", {29'd0, b8.data_valid, b8.par_err, b8.stop_err}, 32'd0);
        rstn = 1'b1;
        idle(8, 2);
        exp8_q.push_back(8'h5A);
        send_frame(8, 8'h5A, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        idle(8, 2);
        expect8("f5a", 1, 0, 0);
        check("f5a_pdata", {24'd0, b8.P_DATA}, 32'h0000_005A);

        // PRESCALE=16 back-to-back 0x3C, 0xC3
        exp16_q.push_back(8'h3C);
        exp16_q.push_back(8'hC3);
        send_frame(16, 8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        send_frame(16, 8'hC3, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        idle(16, 2);
        check("b2b_count", dv16, 2);
        if (dv16_cyc.size() == 2) check("b2b_spacing", dv16_cyc[1] - dv16_cyc[0], 160);
        else check("b2b_spacing_present", dv16_cyc.size(), 2);
        check("b2b_pdata", {24'd0, b16.P_DATA}, 32'h0000_00C3);

        check("exp8_drained", exp8_q.size(), 0);
        check("exp16_drained", exp16_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
